// File: rtl/gated_adder_tree.sv
// gated_adder_tree: pipelined signed pair-add reduction with operand gating and an
// optional accumulator that folds ACC_LEN consecutive tree results into one output word.
module gated_adder_tree #(
  parameter int  IN_W      = 17,
  parameter int  N_IN      = 8,
  parameter int  ACC_LEN   = 1,
  parameter bit  ZERO_IDLE = 1'b1,
  localparam int STG       = $clog2(N_IN),
  localparam int TW        = IN_W + STG,
  localparam int OW        = TW + $clog2(ACC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 clear,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy
);
  localparam int            CW       = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);

  logic [STG-1:0]       v_q, v_d;
  logic [STG:0]         vin_s;
  logic signed [TW-1:0] tree_s;
  logic signed [OW-1:0] tree_ext_s, sum_acc_s;
  logic signed [OW-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d, busy_q, busy_d;

  // vin_s[k] is the valid bit feeding stage k (index 0 is the raw input).
  assign vin_s = {v_q, in_valid};

  for (genvar k = 0; k < STG; k++) begin : g_stg
    localparam int SW = IN_W + k + 1;
    for (genvar j = 0; j < (N_IN >> (k + 1)); j++) begin : g_reg
      logic signed [SW-2:0] a_s, b_s;
      logic signed [SW-1:0] sum_d, sum_q;

      if (k == 0) begin : g_src
        assign a_s = in_data[(2*j)*IN_W +: IN_W];
        assign b_s = in_data[(2*j+1)*IN_W +: IN_W];
      end else begin : g_src
        assign a_s = g_stg[k-1].g_reg[2*j].sum_q;
        assign b_s = g_stg[k-1].g_reg[2*j+1].sum_q;
      end

      // Load only on valid data; otherwise zero or freeze to suppress toggling.
      always_comb begin
        if (!clear && vin_s[k]) begin
          sum_d = {a_s[SW-2], a_s} + {b_s[SW-2], b_s};
        end else if (ZERO_IDLE) begin
          sum_d = {SW{1'b0}};
        end else begin
          sum_d = sum_q;
        end
      end

      // Stage data register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q <= {SW{1'b0}};
        end else begin
          sum_q <= sum_d;
        end
      end
    end
  end

  assign tree_s     = g_stg[STG-1].g_reg[0].sum_q;
  assign tree_ext_s = OW'(tree_s);
  assign sum_acc_s  = (cnt_q == {CW{1'b0}}) ? tree_ext_s : acc_q + tree_ext_s;

  // Valid chain, accumulator and output next-state; clear beats any arriving result.
  always_comb begin
    v_d         = v_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = ZERO_IDLE ? {OW{1'b0}} : out_data_q;
    if (clear) begin
      v_d   = {STG{1'b0}};
      cnt_d = {CW{1'b0}};
      acc_d = {OW{1'b0}};
    end else begin
      v_d = vin_s[STG-1:0];
      if (v_q[STG-1]) begin
        if (cnt_q == CNT_LAST) begin
          out_data_d  = sum_acc_s;
          out_valid_d = 1'b1;
          cnt_d       = {CW{1'b0}};
        end else begin
          acc_d = sum_acc_s;
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
    busy_d = (|v_d) | (cnt_d != {CW{1'b0}}) | out_valid_d;
  end

  // Control, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= {STG{1'b0}};
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {OW{1'b0}};
      out_data_q  <= {OW{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
endmodule
